// File: rtl/uiip_pkg.sv
// Shared constants and FSM state type for the UDP/IP receive path.
package uiip_pkg;
   localparam int          IP_HDR_LEN   = 20;
   localparam logic [7:0]  IP_VER_IHL   = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
   localparam logic [31:0] IP_BCAST     = 32'hFFFF_FFFF;
   localparam int          UDP_MIN_LEN  = 8;

   localparam logic [15:0] HDR_LEN16   = 16'(IP_HDR_LEN);
   localparam logic [15:0] HDR_LAST    = 16'(IP_HDR_LEN - 1);
   localparam logic [15:0] MIN_TOT_LEN = 16'(IP_HDR_LEN + UDP_MIN_LEN);

   typedef enum logic [1:0] {
      WAIT_GAP,
      HDR,
      PAYLOAD,
      DROP
   } rx_state_t;
endpackage

// File: rtl/uiip_csum16.sv
// Ones'-complement 16-bit accumulator with end-around carry; sum shows the folded
// result including the word being added this cycle (zero latency), no backpressure.
module uiip_csum16 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        add,
   input  logic [15:0] word,
   output logic [15:0] sum
);
   logic [15:0] acc;
   logic [16:0] raw;

   // A 16-bit acc plus a 16-bit word folds once without a second carry.
   always_comb begin
      raw = {1'b0, acc} + {1'b0, word};
      sum = add ? (raw[15:0] + {15'd0, raw[16]}) : acc;
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clr) acc <= 16'd0;
      else if (add)        acc <= sum;
   end
endmodule

// File: rtl/uiip_rx_filter.sv
// IPv4 rx filter: forwards UDP payload 1 cycle after input, no backpressure.
// Optional header checksum check is built only when IP_HDR_CSUM_CHK_EN is defined.
module uiip_rx_filter
   import uiip_pkg::*;
(
   input  logic        I_R_ip_clk,
   input  logic        I_reset_n,
   input  logic [31:0] I_local_ip,
   input  logic        I_ip_mac_rvalid,
   input  logic [7:0]  I_ip_mac_rdata,
   output logic        O_udp_ip_rvalid,
   output logic [7:0]  O_udp_ip_rdata,
   output logic [31:0] O_R_ip_src_addr,
   output logic [15:0] O_R_ip_pkg_len,
   output logic        O_R_drop
);
   rx_state_t   state;
   logic [15:0] bcnt;
   logic [7:0]  ver_ihl;
   logic [15:0] tot_len;
   logic        mf_flag;
   logic [12:0] frag_off;
   logic [7:0]  proto;
   logic [31:0] src_ip;
   logic [23:0] dst_hi;
   logic [31:0] dst_ip;
   logic        csum_ok;
   logic        hdr_ok;

   // bcnt is the index of the byte currently on the input.
   always_ff @(posedge I_R_ip_clk) begin
      if (!I_reset_n || !I_ip_mac_rvalid) bcnt <= 16'd0;
      else if (bcnt != 16'hFFFF)          bcnt <= bcnt + 16'd1;
   end

   always_ff @(posedge I_R_ip_clk) begin
      if (!I_reset_n) begin
         ver_ihl  <= 8'd0;
         tot_len  <= 16'd0;
         mf_flag  <= 1'b0;
         frag_off <= 13'd0;
         proto    <= 8'd0;
         src_ip   <= 32'd0;
         dst_hi   <= 24'd0;
      end else if (I_ip_mac_rvalid) begin
         case (bcnt)
            16'd0:  ver_ihl         <= I_ip_mac_rdata;
            16'd2:  tot_len[15:8]   <= I_ip_mac_rdata;
            16'd3:  tot_len[7:0]    <= I_ip_mac_rdata;
            16'd6: begin
               mf_flag         <= I_ip_mac_rdata[5];
               frag_off[12:8]  <= I_ip_mac_rdata[4:0];
            end
            16'd7:  frag_off[7:0]   <= I_ip_mac_rdata;
            16'd9:  proto           <= I_ip_mac_rdata;
            16'd12: src_ip[31:24]   <= I_ip_mac_rdata;
            16'd13: src_ip[23:16]   <= I_ip_mac_rdata;
            16'd14: src_ip[15:8]    <= I_ip_mac_rdata;
            16'd15: src_ip[7:0]     <= I_ip_mac_rdata;
            16'd16: dst_hi[23:16]   <= I_ip_mac_rdata;
            16'd17: dst_hi[15:8]    <= I_ip_mac_rdata;
            16'd18: dst_hi[7:0]     <= I_ip_mac_rdata;
            default: ;
         endcase
      end
   end

`ifdef IP_HDR_CSUM_CHK_EN
   logic [7:0]  prev_byte;
   logic [15:0] csum_sum;

   always_ff @(posedge I_R_ip_clk) begin
      if (!I_reset_n)           prev_byte <= 8'd0;
      else if (I_ip_mac_rvalid) prev_byte <= I_ip_mac_rdata;
   end

   // Words complete on odd byte indices; the last one lands on byte 19.
   uiip_csum16 u_csum (
      .clk     (I_R_ip_clk),
      .reset_n (I_reset_n),
      .clr     (!I_ip_mac_rvalid),
      .add     (I_ip_mac_rvalid && bcnt[0] && (bcnt <= HDR_LAST)),
      .word    ({prev_byte, I_ip_mac_rdata}),
      .sum     (csum_sum)
   );

   assign csum_ok = (csum_sum == 16'hFFFF);
`else
   assign csum_ok = 1'b1;
`endif

   assign dst_ip = {dst_hi, I_ip_mac_rdata};
   assign hdr_ok = (ver_ihl == IP_VER_IHL) && (tot_len >= MIN_TOT_LEN) &&
                   !mf_flag && (frag_off == 13'd0) && (proto == IP_PROTO_UDP) &&
                   ((dst_ip == I_local_ip) || (dst_ip == IP_BCAST)) && csum_ok;

   always_ff @(posedge I_R_ip_clk) begin
      if (!I_reset_n) begin
         state           <= WAIT_GAP;
         O_udp_ip_rvalid <= 1'b0;
         O_udp_ip_rdata  <= 8'd0;
         O_R_ip_src_addr <= 32'd0;
         O_R_ip_pkg_len  <= 16'd0;
         O_R_drop        <= 1'b0;
      end else begin
         O_udp_ip_rvalid <= 1'b0;
         O_udp_ip_rdata  <= 8'd0;
         O_R_drop        <= 1'b0;
         case (state)
            WAIT_GAP: if (!I_ip_mac_rvalid) state <= HDR;
            HDR: begin
               // Idle gaps have bcnt == 0; only a cut-short header is a drop.
               if (!I_ip_mac_rvalid) begin
                  if (bcnt != 16'd0) O_R_drop <= 1'b1;
               end else if (bcnt == HDR_LAST) begin
                  if (hdr_ok) begin
                     state           <= PAYLOAD;
                     O_R_ip_src_addr <= src_ip;
                     O_R_ip_pkg_len  <= tot_len - HDR_LEN16;
                  end else begin
                     state    <= DROP;
                     O_R_drop <= 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (!I_ip_mac_rvalid) begin
                  state    <= HDR;
                  O_R_drop <= 1'b1;
               end else begin
                  O_udp_ip_rvalid <= 1'b1;
                  O_udp_ip_rdata  <= I_ip_mac_rdata;
                  if (bcnt == tot_len - 16'd1) state <= DROP;
               end
            end
            DROP:    if (!I_ip_mac_rvalid) state <= HDR;
            default: state <= WAIT_GAP;
         endcase
      end
   end
endmodule

// File: tb/tb_uiip_rx_filter.sv
// Directed bench for uiip_rx_filter; checksum-corruption step runs when IP_HDR_CSUM_CHK_EN is defined.
module tb_uiip_rx_filter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] local_ip;
   logic        in_vld;
   logic [7:0]  in_dat;
   logic        out_vld;
   logic [7:0]  out_dat;
   logic [31:0] src_addr;
   logic [15:0] pkg_len;
   logic        drop;

   always #5 clk = ~clk;

   uiip_rx_filter dut (
      .I_R_ip_clk      (clk),
      .I_reset_n       (reset_n),
      .I_local_ip      (local_ip),
      .I_ip_mac_rvalid (in_vld),
      .I_ip_mac_rdata  (in_dat),
      .O_udp_ip_rvalid (out_vld),
      .O_udp_ip_rdata  (out_dat),
      .O_R_ip_src_addr (src_addr),
      .O_R_ip_pkg_len  (pkg_len),
      .O_R_drop        (drop)
   );

   int         ncmp = 0;
   int         nfail = 0;
   logic [7:0] pkt [0:127];
   logic [7:0] capq [$];
   int         drops = 0;
   int         runs = 0;
   int         zero_bad = 0;
   logic       prev_vld = 1'b0;
   logic       mon_en = 1'b0;

   // Output monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_vld === 1'b1) begin
            capq.push_back(out_dat);
            if (!prev_vld) runs++;
         end else if (out_dat !== 8'h00) begin
            zero_bad++;
         end
         if (drop === 1'b1) drops++;
         prev_vld = (out_vld === 1'b1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] hdr_csum();
      int s = 0;
      for (int w = 0; w < 10; w++)
         if (w != 5) s += int'({pkt[2*w], pkt[2*w+1]});
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      return ~(16'(s));
   endfunction

   task automatic build(input logic [15:0] total, input int nbytes, input logic [7:0] b0,
                        input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] proto,
                        input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cdelta);
      logic [15:0] c;
      for (int i = 0; i < 128; i++) pkt[i] = 8'h00;
      pkt[0] = b0;           pkt[1] = 8'h00;
      pkt[2] = total[15:8];  pkt[3] = total[7:0];
      pkt[4] = 8'h00;        pkt[5] = 8'h01;
      pkt[6] = b6;           pkt[7] = b7;
      pkt[8] = 8'h40;        pkt[9] = proto;
      pkt[12] = src[31:24];  pkt[13] = src[23:16]; pkt[14] = src[15:8]; pkt[15] = src[7:0];
      pkt[16] = dst[31:24];  pkt[17] = dst[23:16]; pkt[18] = dst[15:8]; pkt[19] = dst[7:0];
      for (int i = 20; i < nbytes; i++)
         pkt[i] = (i < int'(total)) ? 8'(i * 7 + 3) : 8'hEE;
      c = hdr_csum() + cdelta;
      pkt[10] = c[15:8];
      pkt[11] = c[7:0];
   endtask

   task automatic clear_mon();
      capq.delete();
      drops = 0;
      runs = 0;
      zero_bad = 0;
   endtask

   task automatic send(input int n, input int gap);
      clear_mon();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_vld = 1'b1;
         in_dat = pkt[i];
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
      in_dat = 8'h00;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic check_pkt(input string tag, input int exp_n, input int exp_drops);
      int n;
      check({tag, ".count"}, 32'(capq.size()), 32'(exp_n));
      check({tag, ".drops"}, 32'(drops), 32'(exp_drops));
      check({tag, ".runs"},  32'(runs), (exp_n > 0) ? 32'd1 : 32'd0);
      check({tag, ".zero"},  32'(zero_bad), 32'd0);
      n = (capq.size() < exp_n) ? capq.size() : exp_n;
      for (int k = 0; k < n; k++)
         check($sformatf("%s.byte%0d", tag, k), 32'(capq[k]), 32'(pkt[20 + k]));
   endtask

   initial begin
      reset_n  = 1'b0;
      in_vld   = 1'b0;
      in_dat   = 8'h00;
      local_ip = 32'hC0A8_0002;
      repeat (3) @(posedge clk);
      #1;
      check("rst.vld",  32'(out_vld),  32'd0);
      check("rst.dat",  32'(out_dat),  32'd0);
      check("rst.src",  src_addr,      32'd0);
      check("rst.len",  32'(pkg_len),  32'd0);
      check("rst.drop", 32'(drop),     32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Accepted: 40-byte datagram padded to 46, DF set
      build(16'd40, 46, 8'h45, 8'h40, 8'h00, 8'd17, 32'hC0A8_0001, 32'hC0A8_0002, 16'd0);
      send(46, 4);
      check_pkt("good", 20, 0);
      check("good.len", 32'(pkg_len), 32'd20);
      check("good.src", src_addr, 32'hC0A8_0001);

      build(16'd40, 46, 8'h45, 8'h40, 8'h00, 8'd6, 32'hC0A8_0001, 32'hC0A8_0002, 16'd0);
      send(46, 4);
      check_pkt("tcp", 0, 1);

      build(16'd40, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0005, 32'hFFFF_FFFF, 16'd0);
      send(46, 4);
      check_pkt("bcast", 20, 0);
      check("bcast.src", src_addr, 32'hC0A8_0005);

      build(16'd40, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0007, 32'hC0A8_0009, 16'd0);
      send(46, 4);
      check_pkt("dst9", 0, 1);
      check("dst9.src_held", src_addr, 32'hC0A8_0005);

      build(16'd40, 46, 8'h45, 8'h20, 8'h00, 8'd17, 32'hC0A8_0001, 32'hC0A8_0002, 16'd0);
      send(46, 4);
      check_pkt("mf", 0, 1);

      build(16'd40, 46, 8'h45, 8'h00, 8'h01, 8'd17, 32'hC0A8_0001, 32'hC0A8_0002, 16'd0);
      send(46, 4);
      check_pkt("off1", 0, 1);

      build(16'd40, 46, 8'h46, 8'h00, 8'h00, 8'd17, 32'hC0A8_0001, 32'hC0A8_0002, 16'd0);
      send(46, 4);
      check_pkt("ihl6", 0, 1);

      // Minimum legal length, then one byte below it
      build(16'd28, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0003, 32'hC0A8_0002, 16'd0);
      send(46, 3);
      check_pkt("min28", 8, 0);
      check("min28.len", 32'(pkg_len), 32'd8);

      build(16'd27, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0003, 32'hC0A8_0002, 16'd0);
      send(46, 3);
      check_pkt("len27", 0, 1);

      // 60-byte datagram cut after 30 bytes, no gap between payload end and valid low
      build(16'd60, 60, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0004, 32'hC0A8_0002, 16'd0);
      send(30, 4);
      check_pkt("trunc", 10, 1);
      check("trunc.len", 32'(pkg_len), 32'd40);

      // Header cut short at byte 10
      send(10, 3);
      check_pkt("shorthdr", 0, 1);

`ifdef IP_HDR_CSUM_CHK_EN
      build(16'd40, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0001, 32'hC0A8_0002, 16'd1);
      send(46, 4);
      check_pkt("csum_bad", 0, 1);
`endif

      // Reset asserted while byte 25 is on the input
      build(16'd40, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0001, 32'hC0A8_0002, 16'd0);
      clear_mon();
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         in_vld = 1'b1;
         in_dat = pkt[i];
      end
      @(posedge clk); #1;
      in_dat  = pkt[25];
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("rstmid.vld", 32'(out_vld), 32'd0);
      check("rstmid.dat", 32'(out_dat), 32'd0);
      check("rstmid.len", 32'(pkg_len), 32'd0);
      check("rstmid.src", src_addr, 32'd0);
      reset_n = 1'b1;
      in_dat  = pkt[26];
      for (int i = 27; i < 46; i++) begin
         @(posedge clk); #1;
         in_dat = pkt[i];
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
      in_dat = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      check_pkt("rstmid", 5, 0);

      build(16'd40, 46, 8'h45, 8'h00, 8'h00, 8'd17, 32'hC0A8_0006, 32'hC0A8_0002, 16'd0);
      send(46, 4);
      check_pkt("recover", 20, 0);
      check("recover.src", src_addr, 32'hC0A8_0006);
      check("recover.len", 32'(pkg_len), 32'd20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
